bp_be_fe_queue_buffer: RTL and testbench
========================================

BP_BE_FE_QUEUE_BUFFER -- requirements
Module: bp_be_fe_queue_buffer

Interface
REQ-001 SHALL take parameter bp_params_p, default e_bp_default_cfg, selecting the processor configuration and fe_queue_width_lp.
REQ-002 SHALL take parameter els_p, default 8, giving the buffer depth; legal values are powers of two, 2 or greater.
REQ-003 SHALL have port clk_i, input, 1 bit, the single clock.
REQ-004 SHALL have port reset_i, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port fe_queue_i, input, fe_queue_width_lp bits: a bp_fe_queue_s entry from the front end.
REQ-006 SHALL have port fe_queue_v_i, input, 1 bit: the input entry is valid.
REQ-007 SHALL have port fe_queue_ready_and_o, output, 1 bit: the buffer can accept an entry.
REQ-008 SHALL have port fe_queue_o, output, fe_queue_width_lp bits: the entry at the read pointer.
REQ-009 SHALL have port fe_queue_v_o, output, 1 bit: fe_queue_o is valid.
REQ-010 SHALL have port deq_v_i, input, 1 bit: speculatively consume the head entry.
REQ-011 SHALL have port cmt_v_i, input, 1 bit: retire the oldest consumed entry.
REQ-012 SHALL have port roll_v_i, input, 1 bit: replay all consumed, uncommitted entries.
REQ-013 SHALL have port clr_v_i, input, 1 bit: discard all entries.
REQ-014 SHALL have port empty_o, output, 1 bit: no committed-pending or unread entries remain.

Function
REQ-015 SHALL keep three pointers wptr, rptr and cptr, each $clog2(els_p)+1 bits wide; the MSB is a wrap bit and arithmetic is modulo 2*els_p.
REQ-016 SHALL hold the invariant that cptr <= rptr <= wptr in modular order.
REQ-017 SHALL assert full when (wptr - cptr) == els_p; SHALL drive fe_queue_ready_and_o = ~full, which depends on state only.
REQ-018 SHALL enqueue when fe_queue_v_i & fe_queue_ready_and_o: the entry is written at wptr[low bits], and wptr is incremented.
REQ-019 SHALL make an enqueued entry visible on fe_queue_o no earlier than the next cycle; there is no write-to-read bypass.
REQ-020 SHALL drive fe_queue_v_o = (rptr != wptr); fe_queue_o SHALL show the entry at rptr, read combinationally from storage.
REQ-021 SHALL advance rptr by 1 on deq_v_i; deq_v_i while fe_queue_v_o=0 is illegal and SHALL be ignored.
REQ-022 SHALL advance cptr by 1 on cmt_v_i; cmt_v_i while cptr==rptr is illegal and SHALL be ignored.
REQ-023 SHALL, on roll_v_i, set rptr to cptr after any same-cycle commit has been applied; a same-cycle deq_v_i SHALL be ignored and a same-cycle enqueue SHALL proceed.
REQ-024 SHALL, on clr_v_i, set wptr, rptr and cptr to 0; same-cycle deq, cmt, roll and enqueue SHALL all be discarded.
REQ-025 SHALL apply priority clr > roll > (deq, cmt, enq); deq, cmt and enq are otherwise independent within a cycle.
REQ-026 SHALL allow an enqueue and a commit in the same cycle while full; the enqueue is gated by the current-cycle full, so it is not accepted that cycle.
REQ-027 SHALL drive empty_o = (wptr == cptr).
REQ-028 SHALL use pointer wrap-around from 2*els_p-1 to 0 with no special case.

Reset
REQ-029 SHALL, while reset_i is high at a clk_i edge, set wptr, rptr and cptr to 0; all other inputs are ignored that cycle.
REQ-030 SHALL produce these post-reset outputs: fe_queue_v_o=0, fe_queue_ready_and_o=1, empty_o=1, and fe_queue_o undefined.
REQ-031 SHALL leave storage contents unreset.
REQ-032 SHALL, on reset mid-operation, drop all entries in the same manner as clr.

Structure
REQ-033 SHALL use the existing bp_fe_queue_s and declare_bp_core_if; no new package types are needed.
REQ-034 SHALL implement storage with one bsg_mem_1r1w sub-module, width fe_queue_width_lp and els_p entries, with asynchronous read; the pointer logic stays in this module.
REQ-035 SHALL include a simulation-only assertion flagging illegal deq or cmt.

Verification
REQ-036 Reset, then enqueue entries A, B, C on three cycles -> fe_queue_v_o rises in the cycle after A is enqueued; the outputs are A, B, C in order as deq_v_i is pulsed.
REQ-037 With els_p=8, enqueue 8 with no commit -> fe_queue_ready_and_o=0; then deq 1 and cmt 1 -> ready_and returns to 1 in the next cycle, and the 9th entry is accepted.
REQ-038 Enqueue A to D, deq A, B, C, cmt A, then roll -> the next fe_queue_o is B, with ordering B, C, D.
REQ-039 Assert clr_v_i together with an enqueue of E while 5 entries are held -> next cycle empty_o=1, fe_queue_v_o=0, and E is absent.
REQ-040 Stream 20 entries with deq and cmt every cycle -> no loss or duplication across two pointer wraps, and the data matches the input order.
REQ-041 Assert roll_v_i, cmt_v_i and deq_v_i in the same cycle with 3 consumed, uncommitted entries -> cptr+1, rptr equals the new cptr, and the deq is ignored.

Source files
------------

// File: rtl/bp_be_fe_queue_buffer_pkg.sv
// Front-end queue entry format and configuration selection shared by the
// FE queue buffer and its users.
package bp_be_fe_queue_buffer_pkg;

    typedef enum logic [1:0] {
        e_bp_default_cfg = 2'd0,
        e_bp_unicore_cfg = 2'd1
    } bp_params_e;

    typedef enum logic [1:0] {
        e_fe_fetch     = 2'd0,
        e_fe_exception = 2'd1
    } bp_fe_queue_type_e;

    localparam int unsigned vaddr_width_gp  = 39;
    localparam int unsigned instr_width_gp  = 32;
    localparam int unsigned bmeta_width_gp  = 8;

    typedef struct packed {
        bp_fe_queue_type_e           msg_type;
        logic [vaddr_width_gp-1:0]   pc;
        logic [instr_width_gp-1:0]   instr;
        logic [bmeta_width_gp-1:0]   branch_metadata;
    } bp_fe_queue_s;

    // Every configuration currently shares the same entry layout.
    function automatic int unsigned fe_queue_width(input bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return $bits(bp_fe_queue_s);
            default:          return $bits(bp_fe_queue_s);
        endcase
    endfunction

endpackage

// File: rtl/bsg_mem_1r1w.sv
// One-write, one-read register-file memory with asynchronous read.
// Contents are intentionally left unreset.
module bsg_mem_1r1w #(
    parameter int unsigned width_p = 1,
    parameter int unsigned els_p   = 2,
    localparam int unsigned addr_width_lp = $clog2(els_p)
) (
    input  logic                     w_clk_i,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem_r [els_p];

    always_ff @(posedge w_clk_i) begin
        if (w_v_i) begin
            mem_r[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_r[r_addr_i];

endmodule

// File: rtl/bp_be_fe_queue_buffer.sv
// Speculative FE queue buffer: entries are dequeued speculatively, retired by
// commit, and replayed from the commit point on roll.
module bp_be_fe_queue_buffer
    import bp_be_fe_queue_buffer_pkg::*;
#(
    parameter bp_params_e   bp_params_p = e_bp_default_cfg,
    parameter int unsigned  els_p       = 8,
    localparam int unsigned fe_queue_width_lp = fe_queue_width(bp_params_p)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [fe_queue_width_lp-1:0] fe_queue_i,
    input  logic                         fe_queue_v_i,
    output logic                         fe_queue_ready_and_o,
    output logic [fe_queue_width_lp-1:0] fe_queue_o,
    output logic                         fe_queue_v_o,
    input  logic                         deq_v_i,
    input  logic                         cmt_v_i,
    input  logic                         roll_v_i,
    input  logic                         clr_v_i,
    output logic                         empty_o
);

    localparam int unsigned addr_width_lp = $clog2(els_p);
    localparam int unsigned ptr_width_lp  = addr_width_lp + 1;

    typedef logic [ptr_width_lp-1:0] ptr_t;

    ptr_t wptr_r, rptr_r, cptr_r;
    ptr_t wptr_n, rptr_n, cptr_n;

    logic full;
    logic enq;
    logic deq_ok;
    logic cmt_ok;

    // Pointers carry a wrap bit, so occupancy is a plain modular difference.
    assign full   = ((wptr_r - cptr_r) == ptr_t'(els_p));
    assign enq    = fe_queue_v_i & ~full;
    assign deq_ok = deq_v_i & (rptr_r != wptr_r);
    assign cmt_ok = cmt_v_i & (cptr_r != rptr_r);

    assign fe_queue_ready_and_o = ~full;
    assign fe_queue_v_o         = (rptr_r != wptr_r);
    assign empty_o              = (wptr_r == cptr_r);

    always_comb begin
        wptr_n = wptr_r;
        rptr_n = rptr_r;
        cptr_n = cptr_r;
        if (clr_v_i) begin
            wptr_n = '0;
            rptr_n = '0;
            cptr_n = '0;
        end else begin
            if (enq) begin
                wptr_n = wptr_r + ptr_t'(1);
            end
            if (cmt_ok) begin
                cptr_n = cptr_r + ptr_t'(1);
            end
            // Roll replays from the commit point, including this cycle's commit.
            if (roll_v_i) begin
                rptr_n = cptr_n;
            end else if (deq_ok) begin
                rptr_n = rptr_r + ptr_t'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
            cptr_r <= '0;
        end else begin
            wptr_r <= wptr_n;
            rptr_r <= rptr_n;
            cptr_r <= cptr_n;
        end
    end

    bsg_mem_1r1w #(
        .width_p (fe_queue_width_lp),
        .els_p   (els_p)
    ) fifo_mem (
        .w_clk_i  (clk_i),
        .w_v_i    (enq & ~clr_v_i & ~reset_i),
        .w_addr_i (wptr_r[addr_width_lp-1:0]),
        .w_data_i (fe_queue_i),
        .r_addr_i (rptr_r[addr_width_lp-1:0]),
        .r_data_o (fe_queue_o)
    );

    // Simulation check: dequeue needs a visible entry, commit needs a consumed one.
    always_ff @(posedge clk_i) begin
        if (!reset_i && !clr_v_i) begin
            assert (!(deq_v_i && !fe_queue_v_o));
            assert (!(cmt_v_i && (cptr_r == rptr_r)));
        end
    end

endmodule

// File: tb/tb_bp_be_fe_queue_buffer.sv
// Self-checking bench for bp_be_fe_queue_buffer against a queue-based model.
module tb_bp_be_fe_queue_buffer;
    import bp_be_fe_queue_buffer_pkg::*;

    localparam int unsigned W   = fe_queue_width(e_bp_default_cfg);
    localparam int unsigned ELS = 8;

    logic         clk = 1'b0;
    logic         reset_i = 1'b0;
    logic [W-1:0] fe_queue_i = '0;
    logic         fe_queue_v_i = 1'b0;
    logic         fe_queue_ready_and_o;
    logic [W-1:0] fe_queue_o;
    logic         fe_queue_v_o;
    logic         deq_v_i = 1'b0;
    logic         cmt_v_i = 1'b0;
    logic         roll_v_i = 1'b0;
    logic         clr_v_i = 1'b0;
    logic         empty_o;

    int checks = 0;
    int failures = 0;

    // Model: consumed-but-uncommitted entries, then unread entries, oldest first.
    logic [W-1:0] m_cons[$];
    logic [W-1:0] m_unread[$];

    always #5 clk = ~clk;

    bp_be_fe_queue_buffer #(
        .bp_params_p (e_bp_default_cfg),
        .els_p       (ELS)
    ) dut (
        .clk_i                (clk),
        .reset_i              (reset_i),
        .fe_queue_i           (fe_queue_i),
        .fe_queue_v_i         (fe_queue_v_i),
        .fe_queue_ready_and_o (fe_queue_ready_and_o),
        .fe_queue_o           (fe_queue_o),
        .fe_queue_v_o         (fe_queue_v_o),
        .deq_v_i              (deq_v_i),
        .cmt_v_i              (cmt_v_i),
        .roll_v_i             (roll_v_i),
        .clr_v_i              (clr_v_i),
        .empty_o              (empty_o)
    );

    function automatic logic [W-1:0] rnd_entry();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return W'(r);
    endfunction

    // Drive one cycle of inputs and advance the model with the same rules.
    task automatic cycle(input logic enq, input logic [W-1:0] d, input logic deq,
                         input logic cmt, input logic roll, input logic clr,
                         input logic rst);
        bit acc;
        fe_queue_v_i = enq;
        fe_queue_i   = d;
        deq_v_i      = deq;
        cmt_v_i      = cmt;
        roll_v_i     = roll;
        clr_v_i      = clr;
        reset_i      = rst;
        acc = (m_cons.size() + m_unread.size()) < ELS;
        @(posedge clk);
        if (rst || clr) begin
            m_cons.delete();
            m_unread.delete();
        end else begin
            if (cmt && m_cons.size() > 0) void'(m_cons.pop_front());
            if (roll) begin
                while (m_cons.size() > 0) m_unread.push_front(m_cons.pop_back());
            end else if (deq && m_unread.size() > 0) begin
                m_cons.push_back(m_unread.pop_front());
            end
            if (enq && acc) m_unread.push_back(d);
        end
        #1;
        fe_queue_v_i = 1'b0;
        deq_v_i      = 1'b0;
        cmt_v_i      = 1'b0;
        roll_v_i     = 1'b0;
        clr_v_i      = 1'b0;
        reset_i      = 1'b0;
    endtask

    task automatic test_reset();
        cycle(1'b1, rnd_entry(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (fe_queue_v_o !== 1'b0) begin
            failures++; $display("FAIL reset_v got=%b exp=0", fe_queue_v_o);
        end
        checks++;
        if (fe_queue_ready_and_o !== 1'b1) begin
            failures++; $display("FAIL reset_ready got=%b exp=1", fe_queue_ready_and_o);
        end
        checks++;
        if (empty_o !== 1'b1) begin
            failures++; $display("FAIL reset_empty got=%b exp=1", empty_o);
        end
    endtask

    task automatic test_order();
        logic [W-1:0] e [3];
        for (int i = 0; i < 3; i++) e[i] = rnd_entry();
        cycle(1'b1, e[0], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (fe_queue_v_o !== 1'b1) begin
            failures++; $display("FAIL order_v_after_a got=%b exp=1", fe_queue_v_o);
        end
        cycle(1'b1, e[1], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, e[2], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (fe_queue_o !== e[i]) begin
                failures++; $display("FAIL order_data%0d got=%h exp=%h", i, fe_queue_o, e[i]);
            end
            cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (fe_queue_v_o !== 1'b0 || empty_o !== 1'b0) begin
            failures++; $display("FAIL order_drained v=%b empty=%b exp v=0 empty=0", fe_queue_v_o, empty_o);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (empty_o !== 1'b1) begin
            failures++; $display("FAIL order_committed_empty got=%b exp=1", empty_o);
        end
    endtask

    task automatic test_full();
        logic [W-1:0] e [ELS];
        logic [W-1:0] x, n9;
        x  = rnd_entry();
        n9 = rnd_entry();
        for (int i = 0; i < ELS; i++) begin
            e[i] = rnd_entry();
            cycle(1'b1, e[i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (fe_queue_ready_and_o !== 1'b0) begin
            failures++; $display("FAIL full_ready got=%b exp=0", fe_queue_ready_and_o);
        end
        cycle(1'b1, x, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (fe_queue_ready_and_o !== 1'b0) begin
            failures++; $display("FAIL full_after_deq_ready got=%b exp=0", fe_queue_ready_and_o);
        end
        cycle(1'b1, x, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (fe_queue_ready_and_o !== 1'b1) begin
            failures++; $display("FAIL full_after_cmt_ready got=%b exp=1", fe_queue_ready_and_o);
        end
        cycle(1'b1, n9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (fe_queue_ready_and_o !== 1'b0) begin
            failures++; $display("FAIL full_ninth_ready got=%b exp=0", fe_queue_ready_and_o);
        end
        for (int i = 1; i <= ELS; i++) begin
            checks++;
            if (fe_queue_o !== ((i == ELS) ? n9 : e[i])) begin
                failures++; $display("FAIL full_drain%0d got=%h exp=%h", i, fe_queue_o, (i == ELS) ? n9 : e[i]);
            end
            cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (fe_queue_v_o !== 1'b0) begin
            failures++; $display("FAIL full_drained_v got=%b exp=0", fe_queue_v_o);
        end
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_roll();
        logic [W-1:0] e [4];
        for (int i = 0; i < 4; i++) begin
            e[i] = rnd_entry();
            cycle(1'b1, e[i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (fe_queue_v_o !== 1'b1 || fe_queue_o !== e[i]) begin
                failures++; $display("FAIL roll_replay%0d v=%b got=%h exp=%h", i, fe_queue_v_o, fe_queue_o, e[i]);
            end
            cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_clr();
        for (int i = 0; i < 5; i++) cycle(1'b1, rnd_entry(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, rnd_entry(), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (empty_o !== 1'b1 || fe_queue_v_o !== 1'b0 || fe_queue_ready_and_o !== 1'b1) begin
            failures++; $display("FAIL clr_state empty=%b v=%b ready=%b exp 1 0 1", empty_o, fe_queue_v_o, fe_queue_ready_and_o);
        end
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (fe_queue_v_o !== 1'b0) begin
            failures++; $display("FAIL clr_e_absent got=%b exp=0", fe_queue_v_o);
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] s [20];
        int i = 0;
        int j = 0;
        int n = 0;
        bit do_deq, do_cmt;
        for (int k = 0; k < 20; k++) s[k] = rnd_entry();
        while ((j < 20 || m_cons.size() > 0) && n < 100) begin
            do_deq = m_unread.size() > 0;
            do_cmt = m_cons.size() > 0;
            if (do_deq) begin
                checks++;
                if (fe_queue_v_o !== 1'b1 || fe_queue_o !== s[j]) begin
                    failures++; $display("FAIL wrap_data%0d v=%b got=%h exp=%h", j, fe_queue_v_o, fe_queue_o, s[j]);
                end
                j++;
            end
            cycle(i < 20, (i < 20) ? s[i] : '0, do_deq, do_cmt, 1'b0, 1'b0, 1'b0);
            if (i < 20) i++;
            n++;
        end
        checks++;
        if (n >= 100 || j != 20) begin
            failures++; $display("FAIL wrap_timeout cycles=%0d delivered=%0d exp=20", n, j);
        end
        checks++;
        if (empty_o !== 1'b1) begin
            failures++; $display("FAIL wrap_empty got=%b exp=1", empty_o);
        end
    endtask

    task automatic test_roll_cmt_deq();
        logic [W-1:0] e [4];
        for (int i = 0; i < 4; i++) begin
            e[i] = rnd_entry();
            cycle(1'b1, e[i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (fe_queue_v_o !== 1'b1 || fe_queue_o !== e[i]) begin
                failures++; $display("FAIL rcd_replay%0d v=%b got=%h exp=%h", i, fe_queue_v_o, fe_queue_o, e[i]);
            end
            cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (empty_o !== 1'b1) begin
            failures++; $display("FAIL rcd_commit_applied empty=%b exp=1", empty_o);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, rnd_entry(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, rnd_entry(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (empty_o !== 1'b1 || fe_queue_v_o !== 1'b0 || fe_queue_ready_and_o !== 1'b1) begin
            failures++; $display("FAIL midreset empty=%b v=%b ready=%b exp 1 0 1", empty_o, fe_queue_v_o, fe_queue_ready_and_o);
        end
    endtask

    task automatic test_random();
        bit enq, deq, cmt, roll, clr;
        int total;
        for (int n = 0; n < 600; n++) begin
            enq  = $urandom_range(0, 3) != 0;
            deq  = (m_unread.size() > 0) && ($urandom_range(0, 2) != 0);
            cmt  = (m_cons.size() > 0) && ($urandom_range(0, 2) == 0);
            roll = $urandom_range(0, 15) == 0;
            clr  = $urandom_range(0, 63) == 0;
            cycle(enq, rnd_entry(), deq, cmt, roll, clr, 1'b0);
            total = m_cons.size() + m_unread.size();
            checks++;
            if (fe_queue_v_o !== (m_unread.size() > 0) || fe_queue_ready_and_o !== (total < ELS)
                || empty_o !== (total == 0)) begin
                failures++;
                $display("FAIL rand_flags%0d v=%b ready=%b empty=%b exp unread=%0d total=%0d",
                         n, fe_queue_v_o, fe_queue_ready_and_o, empty_o, m_unread.size(), total);
            end
            if (m_unread.size() > 0) begin
                checks++;
                if (fe_queue_o !== m_unread[0]) begin
                    failures++; $display("FAIL rand_data%0d got=%h exp=%h", n, fe_queue_o, m_unread[0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_order();
        test_full();
        test_roll();
        test_clr();
        test_wrap();
        test_roll_cmt_deq();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
